// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: turns a stream of received UART bytes into register writes.
// A frame is SYNC_BYTE, address, data, checksum. The checksum byte makes the
// XOR of all four bytes zero. A good frame produces a one-cycle write strobe.
// A bad checksum, or too long a gap between bytes, produces a one-cycle
// frame_err pulse and bumps a saturating error counter.
module uart_cmd_ctrl #(
  parameter int unsigned CLOCK_FREQUENCY = 100_000_000,
  parameter int unsigned BAUD_RATE       = 115_200,
  parameter logic [7:0]  SYNC_BYTE       = 8'hA5,
  parameter int unsigned TIMEOUT_BYTES   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena_rxd,
  input  logic [7:0] data_i,
  input  logic       err_clr,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_err,
  output logic [7:0] err_cnt,
  output logic       busy
);

  // One 10-bit character time is CLOCK_FREQUENCY/BAUD_RATE * 10 cycles.
  localparam int unsigned TIMEOUT_CYCLES = (CLOCK_FREQUENCY / BAUD_RATE) * 10 * TIMEOUT_BYTES;
  localparam int unsigned TO_W           = $clog2(TIMEOUT_CYCLES + 1);
  // The counter is sampled at the edge where it would step to TIMEOUT_CYCLES-1.
  // Firing on that edge makes frame_err rise TIMEOUT_CYCLES-1 cycles after the
  // last accepted byte.
  localparam logic [TO_W-1:0] TO_FIRE = TO_W'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_CHK  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            ena_q;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic            wr_en_q, wr_en_d;
  logic [7:0]      wr_addr_q, wr_addr_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic            frame_err_q, frame_err_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            busy_q, busy_d;

  logic accept;
  logic timeout;

  // A byte is taken only on the rising edge of the receiver's ready level.
  assign accept  = ena_rxd & ~ena_q;
  // An accepted byte in the same cycle beats the timeout.
  assign timeout = (state_q != S_IDLE) && !accept && (to_cnt_q == TO_FIRE);

  // Next-state, frame assembly, timeout counter and error-count logic.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // a value unassigned and no latch is inferred.
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;
    to_cnt_d    = to_cnt_q + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        to_cnt_d = '0;
        if (accept && (data_i == SYNC_BYTE)) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (accept) begin
          addr_d  = data_i;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          data_d  = data_i;
          state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (accept) begin
          state_d = S_IDLE;
          if ((SYNC_BYTE ^ addr_q ^ data_q ^ data_i) == 8'h00) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = data_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) to_cnt_d = '0;

    if (timeout) begin
      state_d     = S_IDLE;
      frame_err_d = 1'b1;
      to_cnt_d    = '0;
    end

    err_cnt_d = err_cnt_q;
    if (err_clr)                               err_cnt_d = 8'h00;
    else if (frame_err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; a reset aborts any partial frame silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // ena_q resets high so a ready level already present at reset release
      // does not count as a new byte.
      ena_q       <= 1'b1;
      state_q     <= S_IDLE;
      to_cnt_q    <= '0;
      addr_q      <= 8'h00;
      data_q      <= 8'h00;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= 8'h00;
      wr_data_q   <= 8'h00;
      frame_err_q <= 1'b0;
      err_cnt_q   <= 8'h00;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register take its value
      // from the same edge, independent of statement order.
      ena_q       <= ena_rxd;
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_err = frame_err_q;
  assign err_cnt   = err_cnt_q;
  assign busy      = busy_q;

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 100_000_000, system clock in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, serial bit rate.
REQ-003 SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-004 SHALL have parameter TIMEOUT_BYTES, default 4, inter-byte timeout in 10-bit character times.
REQ-005 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port ena_rxd  input  1  receiver byte-ready level from the UART receiver; high while a byte is held.
REQ-008 SHALL have port data_i  input  8  received byte, valid while ena_rxd high.
REQ-009 SHALL have port err_clr  input  1  synchronous clear of err_cnt.
REQ-010 SHALL have port wr_en  output  1  one-cycle register-write strobe.
REQ-011 SHALL have port wr_addr  output  8  write address, held between strobes.
REQ-012 SHALL have port wr_data  output  8  write data, held between strobes.
REQ-013 SHALL have port frame_err  output  1  one-cycle pulse on checksum failure or timeout.
REQ-014 SHALL have port err_cnt  output  8  saturating error count.
REQ-015 SHALL have port busy  output  1  high whenever FSM is not IDLE.

Function
REQ-016 SHALL accept a byte only on a 0->1 transition of ena_rxd (registered previous value); data_i sampled on that edge; a level held high SHALL NOT produce further bytes.
REQ-017 SHALL implement FSM states IDLE, ADDR, DATA, CHK; all outputs registered.
REQ-018 In IDLE, an accepted byte equal to SYNC_BYTE SHALL move to ADDR; any other byte SHALL be discarded with no error.
REQ-019 ADDR SHALL latch the accepted byte as address and move to DATA; DATA SHALL latch data and move to CHK.
REQ-020 In CHK, the accepted byte SHALL be valid when SYNC_BYTE ^ addr ^ data ^ byte == 8'h00.
REQ-021 On valid checksum, wr_addr/wr_data SHALL update and wr_en SHALL be high for exactly the one cycle after the CHK-acceptance edge; FSM returns to IDLE.
REQ-022 On invalid checksum, wr_en, wr_addr and wr_data SHALL be unchanged, frame_err SHALL pulse one cycle after the acceptance edge, err_cnt SHALL increment, FSM returns to IDLE.
REQ-023 Timeout limit SHALL be TIMEOUT_CYCLES = (CLOCK_FREQUENCY/BAUD_RATE)*10*TIMEOUT_BYTES; counter wide enough to hold it without wrap.
REQ-024 Timeout counter SHALL reset to 0 on entry to ADDR and on every accepted byte, increment each cycle in ADDR/DATA/CHK, and hold 0 in IDLE.
REQ-025 On counter reaching TIMEOUT_CYCLES-1, FSM SHALL return to IDLE, frame_err SHALL pulse one cycle, err_cnt SHALL increment; partial frame discarded, no write.
REQ-026 A byte accepted in the same cycle the timeout would fire SHALL take priority; no timeout is raised.
REQ-027 err_cnt SHALL saturate at 8'hFF; err_clr SHALL set it to 0 and wins over a simultaneous increment.
REQ-028 A SYNC_BYTE value received in ADDR, DATA or CHK SHALL be treated as ordinary payload, not a resync.
REQ-029 Back-to-back frames SHALL be accepted with no idle gap required between CHK and the next SYNC_BYTE.

Reset
REQ-030 While rst_n low: FSM IDLE, wr_en 0, wr_addr 0, wr_data 0, frame_err 0, err_cnt 0, busy 0, timeout counter 0.
REQ-031 Registered previous ena_rxd SHALL reset to 1, so ena_rxd high at reset release yields no byte.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no wr_en and no frame_err.

Verification
REQ-033 Bytes A5,10,3C,89 -> one wr_en pulse, wr_addr=8'h10, wr_data=8'h3C, frame_err never high, err_cnt=0.
REQ-034 Bytes A5,10,3C,88 -> no wr_en, single frame_err pulse, err_cnt=1, wr_addr/wr_data keep prior values.
REQ-035 Bytes A5,10 then silence -> frame_err pulse exactly TIMEOUT_CYCLES-1 cycles after 8'h10 accepted, busy falls, err_cnt=1.
REQ-036 Release rst_n with ena_rxd held high 1000 cycles, then bytes 00,FF,A5,01,02,A6 -> only one write (addr 01, data 02), no frame_err.
REQ-037 256 bad-checksum frames -> err_cnt=8'hFF and holds; err_clr asserted in same cycle as a 257th failure -> err_cnt=0.
REQ-038 Two frames back-to-back (A5,01,02,A6,A5,03,04,A2) -> two wr_en pulses, second with wr_addr=03, wr_data=04.
